// File: rtl/mult_reg_datapath.sv
// X:A:B product register chain and 9-bit sign-extended add/subtract for the shift-add multiplier.
// Each strobe acts on the edge where it is sampled high; there is no pipelining and no backpressure.
module mult_reg_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift_En,
  input  logic             Clear_XA,
  input  logic             Clear_Load,
  input  logic             LoadB,
  output logic             M,
  output logic             Xval,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] sw_ext;
  logic [WIDTH:0] sum;
  logic           arith;

  assign a_ext  = {a_q[WIDTH-1], a_q};
  assign sw_ext = {SW[WIDTH-1], SW};
  // Subtract is add of the inverted operand with carry-in of one; wraps modulo 2^(WIDTH+1).
  assign sum    = a_ext + (Sub ? ~sw_ext : sw_ext) + {{WIDTH{1'b0}}, Sub};
  assign arith  = Add | Sub;

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (Clear_Load) begin
      x_d = 1'b0;
      a_d = '0;
      b_d = SW;
    end else begin
      if (Clear_XA) begin
        x_d = 1'b0;
        a_d = '0;
      end else if (arith) begin
        x_d = sum[WIDTH];
        a_d = sum[WIDTH-1:0];
      end else if (Shift_En) begin
        a_d = {x_q, a_q[WIDTH-1:1]};
      end
      // B still shifts in the old A[0] when only X,A are being cleared.
      if (LoadB) begin
        b_d = SW;
      end else if (Shift_En && !arith) begin
        b_d = {a_q[0], b_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign M    = b_q[0];
  assign Xval = x_q;
  assign Aval = a_q;
  assign Bval = b_q;

endmodule

// File: tb/tb_mult_reg_datapath.sv
// Directed bench for mult_reg_datapath: reset, multiply sequences, strobe priority and wrap boundaries.
module tb_mult_reg_datapath;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] SW;
  logic       Add, Sub, Shift_En, Clear_XA, Clear_Load, LoadB;
  logic       M, Xval;
  logic [7:0] Aval, Bval;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  mult_reg_datapath #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .SW(SW),
    .Add(Add), .Sub(Sub), .Shift_En(Shift_En),
    .Clear_XA(Clear_XA), .Clear_Load(Clear_Load), .LoadB(LoadB),
    .M(M), .Xval(Xval), .Aval(Aval), .Bval(Bval)
  );

  task automatic clr_strobes();
    Add = 0; Sub = 0; Shift_En = 0; Clear_XA = 0; Clear_Load = 0; LoadB = 0;
  endtask

  // One edge with the given strobes; returns 1 time unit after the edge with strobes dropped.
  task automatic drive(input logic cl, input logic cx, input logic lb, input logic sb,
                       input logic ad, input logic sh, input logic [7:0] sw);
    Clear_Load = cl; Clear_XA = cx; LoadB = lb; Sub = sb; Add = ad; Shift_En = sh; SW = sw;
    @(posedge Clk); #1;
    clr_strobes();
  endtask

  // Plays the control FSM role for iterations [0, n_iter).
  task automatic fsm_iters(input logic [7:0] s, input int n_iter);
    for (int i = 0; i < n_iter; i++) begin
      if (M) drive(0, 0, 0, (i == 7), (i != 7), 0, s);
      drive(0, 0, 0, 0, 0, 1, s);
    end
  endtask

  task automatic run_mult(input logic [7:0] b, input logic [7:0] s);
    drive(1, 0, 0, 0, 0, 0, b);
    SW = s;
    fsm_iters(s, 8);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({Xval, Aval, Bval, M} !== 18'h0) begin n_bad++;
      $display("FAIL reset_state: X/A/B/M=%b/%h/%h/%b want 0/00/00/0", Xval, Aval, Bval, M); end
    Reset = 1;
    @(posedge Clk); #1;
    n_cmp++; if ({Xval, Aval, Bval} !== 17'h0) begin n_bad++;
      $display("FAIL reset_release_hold: X/A/B=%b/%h/%h want 0/00/00", Xval, Aval, Bval); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 8'h07);
    SW = 8'h03;
    fsm_iters(8'h03, 3);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h02, 8'hA0}) begin n_bad++;
      $display("FAIL mid_multiply: X/A/B=%b/%h/%h want 0/02/a0", Xval, Aval, Bval); end
    #3 Reset = 0;
    #1;
    n_cmp++; if ({Xval, Aval, Bval, M} !== 18'h0) begin n_bad++;
      $display("FAIL async_reset: X/A/B/M=%b/%h/%h/%b want 0/00/00/0", Xval, Aval, Bval, M); end
    Clear_Load = 1; Add = 1; Shift_En = 1; SW = 8'h55;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++; if ({Xval, Aval, Bval, M} !== 18'h0) begin n_bad++;
      $display("FAIL reset_held: X/A/B/M=%b/%h/%h/%b want 0/00/00/0", Xval, Aval, Bval, M); end
    clr_strobes();
    Reset = 1;
    @(posedge Clk); #1;
    n_cmp++; if ({Xval, Aval, Bval} !== 17'h0) begin n_bad++;
      $display("FAIL post_reset_idle: X/A/B=%b/%h/%h want 0/00/00", Xval, Aval, Bval); end
  endtask

  task automatic test_mult_basic();
    drive(1, 0, 0, 0, 0, 0, 8'h07);
    n_cmp++; if ({Xval, Aval, Bval, M} !== {1'b0, 8'h00, 8'h07, 1'b1}) begin n_bad++;
      $display("FAIL clear_load: X/A/B/M=%b/%h/%h/%b want 0/00/07/1", Xval, Aval, Bval, M); end
    SW = 8'h03;
    fsm_iters(8'h03, 8);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 16'h0015}) begin n_bad++;
      $display("FAIL mult_7x3: X/AB=%b/%h want 0/0015", Xval, {Aval, Bval}); end
  endtask

  task automatic test_mult_signed();
    run_mult(8'hFD, 8'h05);
    n_cmp++; if ({Aval, Bval} !== 16'hFFF1) begin n_bad++;
      $display("FAIL mult_m3x5: AB=%h want fff1", {Aval, Bval}); end
    run_mult(8'h05, 8'hFD);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b1, 16'hFFF1}) begin n_bad++;
      $display("FAIL mult_5xm3: X/AB=%b/%h want 1/fff1", Xval, {Aval, Bval}); end
  endtask

  task automatic test_mult_extremes();
    run_mult(8'h80, 8'h80);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 16'h4000}) begin n_bad++;
      $display("FAIL mult_m128xm128: X/AB=%b/%h want 0/4000", Xval, {Aval, Bval}); end
    run_mult(8'h7F, 8'h7F);
    n_cmp++; if ({Aval, Bval} !== 16'h3F01) begin n_bad++;
      $display("FAIL mult_127x127: AB=%h want 3f01", {Aval, Bval}); end
    run_mult(8'h7F, 8'h80);
    n_cmp++; if ({Aval, Bval} !== 16'hC080) begin n_bad++;
      $display("FAIL mult_127xm128: AB=%h want c080", {Aval, Bval}); end
  endtask

  task automatic test_priority();
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 1, 0, 8'h10);
    drive(0, 0, 1, 0, 0, 0, 8'hA5);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h10, 8'hA5}) begin n_bad++;
      $display("FAIL setup_a10: X/A/B=%b/%h/%h want 0/10/a5", Xval, Aval, Bval); end
    drive(0, 0, 0, 1, 1, 1, 8'h01);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h0F, 8'hA5}) begin n_bad++;
      $display("FAIL add_sub_shift: X/A/B=%b/%h/%h want 0/0f/a5", Xval, Aval, Bval); end
    drive(1, 0, 0, 0, 1, 0, 8'h3C);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h00, 8'h3C}) begin n_bad++;
      $display("FAIL clear_load_add: X/A/B=%b/%h/%h want 0/00/3c", Xval, Aval, Bval); end
    drive(0, 0, 0, 0, 1, 0, 8'h22);
    drive(0, 1, 1, 0, 0, 1, 8'h66);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h00, 8'h66}) begin n_bad++;
      $display("FAIL clrxa_loadb_shift: X/A/B=%b/%h/%h want 0/00/66", Xval, Aval, Bval); end
    drive(0, 0, 1, 1, 0, 0, 8'h01);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b1, 8'hFF, 8'h01}) begin n_bad++;
      $display("FAIL loadb_sub: X/A/B=%b/%h/%h want 1/ff/01", Xval, Aval, Bval); end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0, 0, 0, 8'hC3);
    drive(0, 0, 0, 0, 1, 0, 8'h7F);
    drive(0, 0, 0, 0, 1, 0, 8'h01);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h80, 8'hC3}) begin n_bad++;
      $display("FAIL add_7f_01: X/A/B=%b/%h/%h want 0/80/c3", Xval, Aval, Bval); end
    drive(0, 0, 0, 0, 0, 1, 8'h01);
    n_cmp++; if ({Xval, Aval, Bval, M} !== {1'b0, 8'h40, 8'h61, 1'b1}) begin n_bad++;
      $display("FAIL shift_after_ovf: X/A/B/M=%b/%h/%h/%b want 0/40/61/1", Xval, Aval, Bval, M); end
    drive(0, 0, 0, 0, 0, 0, 8'hFF);
    n_cmp++; if ({Xval, Aval, Bval} !== {1'b0, 8'h40, 8'h61}) begin n_bad++;
      $display("FAIL idle_hold: X/A/B=%b/%h/%h want 0/40/61", Xval, Aval, Bval); end
    drive(0, 1, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 0, 8'h80);
    n_cmp++; if ({Xval, Aval} !== {1'b0, 8'h80}) begin n_bad++;
      $display("FAIL sub_0_m128: X/A=%b/%h want 0/80", Xval, Aval); end
    drive(0, 0, 0, 1, 0, 0, 8'h01);
    n_cmp++; if ({Xval, Aval} !== {1'b1, 8'h7F}) begin n_bad++;
      $display("FAIL sub_m128_1: X/A=%b/%h want 1/7f", Xval, Aval); end
  endtask

  initial begin
    Reset = 0;
    SW = 8'h00;
    clr_strobes();
    test_reset();
    test_reset_mid();
    test_mult_basic();
    test_mult_signed();
    test_mult_extremes();
    test_priority();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
